// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: on an enabled request at an instruction boundary it
// stalls the core, reads the interrupt number from the controller, and redirects fetch.
module interrupt_sequencer #(
   parameter logic [15:0] CTRL_ADDR   = 16'h0410,
   parameter logic [15:0] VECTOR_BASE = 16'h0020
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_int,
   input  logic        i_gie,
   input  logic        i_boundary,
   input  logic [15:0] i_pc,
   input  logic        i_reti,
   output logic        o_bus_req,
   input  logic        i_bus_gnt,
   output logic [15:0] o_addr,
   output logic        o_we,
   input  logic [15:0] i_data,
   output logic        o_stall,
   output logic        o_redirect,
   output logic [15:0] o_redirect_pc,
   output logic        o_in_isr,
   output logic [3:0]  o_irq_idx,
   output logic        o_spurious
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_BUS_REQ  = 3'd1;
   localparam logic [2:0] S_ADDR     = 3'd2;
   localparam logic [2:0] S_CAPTURE  = 3'd3;
   localparam logic [2:0] S_DISPATCH = 3'd4;
   localparam logic [2:0] S_IN_ISR   = 3'd5;
   localparam logic [2:0] S_RETURN   = 3'd6;

   logic [2:0]  state_q, state_d;
   logic [15:0] saved_pc_q, saved_pc_d;
   logic [15:0] num_word_q, num_word_d;
   logic [3:0]  irq_idx_q, irq_idx_d;

   logic [3:0]  enc_idx;
   logic [15:0] vector_pc;
   logic        num_zero;

   // Lowest set bit wins: scanning downward leaves the smallest index last.
   always_comb begin
      enc_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (num_word_q[i]) begin
            enc_idx = i[3:0];
         end
      end
   end

   assign num_zero  = (num_word_q == 16'h0000);
   assign vector_pc = VECTOR_BASE + {10'b0, enc_idx, 2'b00};

   always_comb begin
      state_d    = state_q;
      saved_pc_d = saved_pc_q;
      num_word_d = num_word_q;
      irq_idx_d  = irq_idx_q;
      case (state_q)
         S_IDLE: begin
            if (i_int && i_gie && i_boundary) begin
               state_d    = S_BUS_REQ;
               saved_pc_d = i_pc;
            end
         end
         S_BUS_REQ: begin
            if (i_bus_gnt) begin
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            num_word_d = i_data;
            state_d    = S_DISPATCH;
         end
         S_DISPATCH: begin
            if (num_zero) begin
               state_d = S_IDLE;
            end else begin
               irq_idx_d = enc_idx;
               state_d   = S_IN_ISR;
            end
         end
         S_IN_ISR: begin
            if (i_reti) begin
               state_d = S_RETURN;
            end
         end
         S_RETURN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         saved_pc_q <= 16'h0000;
         num_word_q <= 16'h0000;
         irq_idx_q  <= 4'd0;
      end else begin
         state_q    <= state_d;
         saved_pc_q <= saved_pc_d;
         num_word_q <= num_word_d;
         irq_idx_q  <= irq_idx_d;
      end
   end

   // Outputs decode only registered state, so reset clears them without waiting for a clock.
   always_comb begin
      o_bus_req     = 1'b0;
      o_addr        = 16'h0000;
      o_stall       = 1'b1;
      o_redirect    = 1'b0;
      o_redirect_pc = 16'h0000;
      o_in_isr      = 1'b0;
      o_spurious    = 1'b0;
      case (state_q)
         S_IDLE: begin
            o_stall = 1'b0;
         end
         S_BUS_REQ: begin
            o_bus_req = 1'b1;
         end
         S_ADDR, S_CAPTURE: begin
            o_bus_req = 1'b1;
            o_addr    = CTRL_ADDR;
         end
         S_DISPATCH: begin
            if (num_zero) begin
               o_spurious = 1'b1;
            end else begin
               o_redirect    = 1'b1;
               o_redirect_pc = vector_pc;
            end
         end
         S_IN_ISR: begin
            o_stall  = 1'b0;
            o_in_isr = 1'b1;
         end
         S_RETURN: begin
            o_redirect    = 1'b1;
            o_redirect_pc = saved_pc_q;
         end
         default: begin
            o_stall = 1'b0;
         end
      endcase
   end

   assign o_we      = 1'b0;
   assign o_irq_idx = irq_idx_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: a table of controller words plus hand-written
// sequences for bus-grant stalls, no-nesting, reti filtering and mid-sequence reset.
module tb_interrupt_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        int_r, gie, boundary, reti, gnt;
   logic [15:0] pc;
   logic [15:0] bus_data;
   logic [15:0] ctrl_val;
   logic        bus_req, we, stall, redirect, in_isr, spurious;
   logic [15:0] addr, redirect_pc;
   logic [3:0]  irq_idx;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   interrupt_sequencer dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_int         (int_r),
      .i_gie         (gie),
      .i_boundary    (boundary),
      .i_pc          (pc),
      .i_reti        (reti),
      .o_bus_req     (bus_req),
      .i_bus_gnt     (gnt),
      .o_addr        (addr),
      .o_we          (we),
      .i_data        (bus_data),
      .o_stall       (stall),
      .o_redirect    (redirect),
      .o_redirect_pc (redirect_pc),
      .o_in_isr      (in_isr),
      .o_irq_idx     (irq_idx),
      .o_spurious    (spurious)
   );

   // Controller model: read data appears one cycle after the address is presented.
   always @(posedge clk) begin
      bus_data <= (addr == 16'h0410) ? ctrl_val : 16'hBAD0;
   end

   typedef struct {
      logic [15:0] data;
      logic [15:0] pc;
      logic        spur;
      logic [3:0]  idx;
      logic [15:0] vec_pc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_outs();
      return {22'd0, bus_req, addr, we, stall, redirect, redirect_pc, in_isr, irq_idx, spurious};
   endfunction

   initial begin
      vecs[0] = '{16'h0008, 16'h0123, 1'b0, 4'd3,  16'h002C};
      vecs[1] = '{16'h8005, 16'h4567, 1'b0, 4'd0,  16'h0020};
      vecs[2] = '{16'h0000, 16'h1111, 1'b1, 4'd0,  16'h0000};
      vecs[3] = '{16'h8000, 16'hFFFC, 1'b0, 4'd15, 16'h005C};
      vecs[4] = '{16'h0100, 16'h0AB0, 1'b0, 4'd8,  16'h0040};
      vecs[5] = '{16'h0060, 16'h7FFE, 1'b0, 4'd5,  16'h0034};

      rst = 1'b1; int_r = 1'b0; gie = 1'b0; boundary = 1'b0; reti = 1'b0;
      gnt = 1'b0; pc = 16'h0000; ctrl_val = 16'h0000;
      #3;
      chk("reset_outputs", all_outs(), 64'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("idle_after_reset", all_outs(), 64'd0);

      // Table of controller words, each run through a full entry (and exit when not spurious).
      for (int v = 0; v < 6; v++) begin
         $display("vector %0d: data=%h pc=%h", v, vecs[v].data, vecs[v].pc);
         ctrl_val = vecs[v].data;
         int_r = 1'b1; gie = 1'b1; boundary = 1'b1; gnt = 1'b1; pc = vecs[v].pc;
         step();
         int_r = 1'b0; gie = 1'b0; pc = 16'hFFFF;
         chk("busreq_req", bus_req, 1'b1);
         chk("busreq_stall", stall, 1'b1);
         chk("busreq_addr", addr, 16'h0000);
         step();
         chk("addr_cycle1", addr, 16'h0410);
         step();
         chk("addr_cycle2", addr, 16'h0410);
         chk("capture_we", we, 1'b0);
         step();
         chk("dispatch_busreq", bus_req, 1'b0);
         chk("dispatch_addr", addr, 16'h0000);
         chk("dispatch_stall", stall, 1'b1);
         chk("dispatch_redirect", redirect, !vecs[v].spur);
         chk("dispatch_pc", redirect_pc, vecs[v].vec_pc);
         chk("dispatch_spurious", spurious, vecs[v].spur);
         step();
         chk("post_redirect", redirect, 1'b0);
         chk("post_spurious", spurious, 1'b0);
         chk("post_stall", stall, 1'b0);
         chk("post_in_isr", in_isr, !vecs[v].spur);
         if (!vecs[v].spur) begin
            chk("isr_idx", irq_idx, vecs[v].idx);
            step();
            chk("isr_hold", in_isr, 1'b1);
            reti = 1'b1;
            step();
            reti = 1'b0;
            chk("return_redirect", redirect, 1'b1);
            chk("return_pc", redirect_pc, vecs[v].pc);
            chk("return_in_isr", in_isr, 1'b0);
            chk("return_stall", stall, 1'b1);
            step();
            chk("exit_idle_stall", stall, 1'b0);
            chk("exit_idle_redirect", redirect, 1'b0);
            chk("exit_idle_pc", redirect_pc, 16'h0000);
         end else begin
            step();
            chk("spur_stays_idle", stall, 1'b0);
         end
      end

      // Request held while disabled or off-boundary stays pending.
      $display("sequence: gated request then grant delay");
      ctrl_val = 16'h0100;
      int_r = 1'b1; gie = 1'b0; boundary = 1'b1; gnt = 1'b0; pc = 16'h0BEE;
      step();
      chk("gie0_no_start", {bus_req, stall}, 2'b00);
      gie = 1'b1; boundary = 1'b0;
      step();
      chk("boundary0_no_start", {bus_req, stall}, 2'b00);
      boundary = 1'b1;
      step();
      int_r = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("nogrant_busreq", bus_req, 1'b1);
         chk("nogrant_stall", stall, 1'b1);
         chk("nogrant_addr", addr, 16'h0000);
         reti = (c == 2);
         step();
      end
      reti = 1'b0;
      chk("nogrant_still_waiting", {bus_req, addr}, {1'b1, 16'h0000});
      gnt = 1'b1;
      step();
      chk("grant_addr", addr, 16'h0410);
      step();
      step();
      chk("grant_dispatch_pc", redirect_pc, 16'h0040);
      step();
      chk("grant_in_isr", in_isr, 1'b1);
      for (int c = 0; c < 4; c++) begin
         int_r = c[0];
         step();
         chk("nest_in_isr", in_isr, 1'b1);
         chk("nest_busreq", bus_req, 1'b0);
         chk("nest_stall", stall, 1'b0);
      end
      int_r = 1'b0;
      reti = 1'b1;
      step();
      reti = 1'b0;
      chk("nest_return_pc", redirect_pc, 16'h0BEE);
      step();
      chk("nest_back_idle", {stall, in_isr}, 2'b00);

      // Reset in CAPTURE aborts immediately.
      $display("sequence: reset during capture");
      ctrl_val = 16'h0002;
      int_r = 1'b1; gie = 1'b1; boundary = 1'b1; gnt = 1'b1; pc = 16'h2222;
      step();
      int_r = 1'b0;
      step();
      step();
      chk("rst_capture_addr", addr, 16'h0410);
      chk("rst_prev_idx", irq_idx, 4'd8);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", all_outs(), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("rst_release_idle", all_outs(), 64'd0);
      step();
      chk("rst_stays_idle", {bus_req, stall, redirect}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
